timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 134 +++++++++++++
 tb/tb_timer_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Microwave-style mm:ss timer controller. It takes keypad digits into a
// BCD entry register, loads them into an external down-counter cascade,
// gates the count enable while cooking, and holds a done indication for a
// fixed number of ticks before returning to the entry state.
//
// state | meaning
// SET   | idle, keypad entry accepted, waiting for start
// LOAD  | one-cycle parallel load of the entry into the counter cascade
// RUN   | heater on, cascade counts down on each tick
// PAUSE | heater off, count frozen, resume without reload or stop to abort
// DONE  | count reached zero, done held for DONE_HOLD ticks
module timer_ctrl #(
    parameter int DONE_HOLD = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic        loadn,
    output logic [15:0] load_data,
    output logic        en,
    output logic        mag_on,
    output logic        done
);

    // The counter only needs to reach DONE_HOLD-1; the last tick exits DONE.
    localparam int CW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        SET   = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     entry, entry_nxt;
    logic [CW-1:0]   hold_cnt, hold_cnt_nxt;

    assign load_data = entry;

    // State, entry register and done-hold counter; clear overrides everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= SET;
            entry    <= 16'h0000;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            entry    <= entry_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic plus state-decoded outputs; en is the only output
    // that also looks at inputs, so the cascade stops exactly at 00:00.
    always_comb begin
        state_nxt    = state;
        entry_nxt    = entry;
        hold_cnt_nxt = hold_cnt;
        loadn        = 1'b1;
        en           = 1'b0;
        mag_on       = 1'b0;
        done         = 1'b0;

        case (state)
            SET: begin
                if (stop) begin
                    entry_nxt = 16'h0000;
                end else if (start && door_closed && (entry != 16'h0000)) begin
                    state_nxt = LOAD;
                end else if (key_valid && (key_digit <= 4'd9)) begin
                    entry_nxt = {entry[11:0], key_digit};
                end
            end

            LOAD: begin
                loadn     = 1'b0;
                state_nxt = RUN;
            end

            RUN: begin
                mag_on = 1'b1;
                en     = tick & ~timer_zero;
                if (!door_closed) begin
                    state_nxt = PAUSE;
                end else if (stop) begin
                    state_nxt = PAUSE;
                end else if (timer_zero) begin
                    state_nxt    = DONE;
                    hold_cnt_nxt = '0;
                end
            end

            PAUSE: begin
                if (stop) begin
                    state_nxt = SET;
                    entry_nxt = 16'h0000;
                end else if (start && door_closed) begin
                    state_nxt = RUN;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start || stop) begin
                    state_nxt = SET;
                    entry_nxt = 16'h0000;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt    = SET;
                        entry_nxt    = 16'h0000;
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CW'(1);
                    end
                end
            end

            default: begin
                state_nxt = SET;
                entry_nxt = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: each scenario drives one cycle at a time, pushing
// the expected {loadn, load_data, en, mag_on, done} into a queue and the
// sampled DUT outputs into a second queue, then compares them in order.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        clear, tick, key_valid, start, stop, door_closed, timer_zero;
    logic [3:0]  key_digit;
    logic        loadn, en, mag_on, done;
    logic [15:0] load_data;

    logic [19:0] exp_q[$];
    logic [19:0] act_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    timer_ctrl #(.DONE_HOLD(5)) dut (
        .clk(clk), .clear(clear), .tick(tick), .key_valid(key_valid),
        .key_digit(key_digit), .start(start), .stop(stop),
        .door_closed(door_closed), .timer_zero(timer_zero),
        .loadn(loadn), .load_data(load_data), .en(en),
        .mag_on(mag_on), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] E(input logic ld, input logic [15:0] d,
                                      input logic e, input logic m, input logic dn);
        return {ld, d, e, m, dn};
    endfunction

    // One clock: drive inputs just after the rising edge, record expected
    // outputs, sample the DUT on the falling edge, then advance.
    task automatic cyc(input logic t, input logic kv, input logic [3:0] kd,
                       input logic st, input logic sp, input logic dc,
                       input logic tz, input logic cl,
                       input logic [19:0] exp, input string nm);
        tick = t; key_valid = kv; key_digit = kd; start = st; stop = sp;
        door_closed = dc; timer_zero = tz; clear = cl;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        act_q.push_back({loadn, load_data, en, mag_on, done});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] e, a; string n;
        cyc(1, 1, 4'd5, 1, 0, 1, 0, 1, E(1, 16'h0000, 0, 0, 0), "reset_override");
        cyc(1, 1, 4'd6, 1, 0, 1, 0, 1, E(1, 16'h0000, 0, 0, 0), "reset_hold");
        cyc(0, 0, 4'd0, 0, 0, 0, 0, 0, E(1, 16'h0000, 0, 0, 0), "reset_release");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_keys();
        logic [19:0] e, a; string n;
        cyc(0, 1, 4'd1,  0, 0, 0, 0, 0, E(1, 16'h0000, 0, 0, 0), "key1");
        cyc(0, 1, 4'd3,  0, 0, 0, 0, 0, E(1, 16'h0001, 0, 0, 0), "key3");
        cyc(0, 1, 4'd0,  0, 0, 0, 0, 0, E(1, 16'h0013, 0, 0, 0), "key0");
        cyc(0, 1, 4'd12, 0, 0, 0, 0, 0, E(1, 16'h0130, 0, 0, 0), "entry_0130");
        cyc(0, 1, 4'd4,  0, 0, 0, 0, 0, E(1, 16'h0130, 0, 0, 0), "key12_ignored");
        cyc(0, 1, 4'd5,  0, 0, 0, 0, 0, E(1, 16'h1304, 0, 0, 0), "key4");
        cyc(0, 0, 4'd7,  0, 0, 0, 0, 0, E(1, 16'h3045, 0, 0, 0), "entry_3045");
        cyc(0, 0, 4'd0,  0, 0, 0, 0, 0, E(1, 16'h3045, 0, 0, 0), "no_strobe_ignored");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_start_stop();
        logic [19:0] e, a; string n;
        cyc(0, 0, 4'd0, 0, 1, 0, 0, 0, E(1, 16'h3045, 0, 0, 0), "stop_in_set");
        cyc(0, 1, 4'd1, 0, 0, 0, 0, 0, E(1, 16'h0000, 0, 0, 0), "stop_cleared");
        cyc(0, 1, 4'd3, 0, 0, 0, 0, 0, E(1, 16'h0001, 0, 0, 0), "rekey1");
        cyc(0, 1, 4'd0, 0, 0, 0, 0, 0, E(1, 16'h0013, 0, 0, 0), "rekey3");
        cyc(0, 0, 4'd0, 1, 1, 1, 0, 0, E(1, 16'h0130, 0, 0, 0), "start_stop_same");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "stop_wins");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "start_zero_entry");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_run_done();
        logic [19:0] e, a; string n;
        cyc(0, 1, 4'd5, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "key5");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0005, 0, 0, 0), "start_in_set");
        cyc(1, 0, 4'd0, 0, 0, 1, 0, 0, E(0, 16'h0005, 0, 0, 0), "load_cycle");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0005, 0, 1, 0), "run_no_tick");
        cyc(1, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0005, 1, 1, 0), "run_tick1");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0005, 0, 1, 0), "run_gap");
        cyc(1, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0005, 1, 1, 0), "run_tick2");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 1, 0), "zero_blocks_en");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_tick1");
        cyc(0, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_gap");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_tick2");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_tick3");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_tick4");
        cyc(1, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0005, 0, 0, 1), "done_tick5");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "done_to_set");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_pause();
        logic [19:0] e, a; string n;
        cyc(0, 1, 4'd9, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "key9");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0009, 0, 0, 0), "start9");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(0, 16'h0009, 0, 0, 0), "load9");
        cyc(1, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0009, 1, 1, 0), "run9_tick");
        cyc(1, 0, 4'd0, 0, 0, 0, 0, 0, E(1, 16'h0009, 1, 1, 0), "door_open_run");
        cyc(1, 0, 4'd0, 0, 0, 0, 0, 0, E(1, 16'h0009, 0, 0, 0), "paused_tick");
        cyc(0, 0, 4'd0, 1, 0, 0, 0, 0, E(1, 16'h0009, 0, 0, 0), "start_door_open");
        cyc(0, 0, 4'd0, 0, 0, 0, 0, 0, E(1, 16'h0009, 0, 0, 0), "still_paused");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0009, 0, 0, 0), "resume_req");
        cyc(1, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0009, 1, 1, 0), "resumed_no_load");
        cyc(0, 0, 4'd0, 0, 1, 1, 0, 0, E(1, 16'h0009, 0, 1, 0), "stop_in_run");
        cyc(0, 0, 4'd0, 0, 1, 1, 0, 0, E(1, 16'h0009, 0, 0, 0), "stop_in_pause");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "pause_to_set");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_done_start();
        logic [19:0] e, a; string n;
        cyc(0, 1, 4'd2, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "key2");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0002, 0, 0, 0), "start2");
        cyc(0, 0, 4'd0, 0, 0, 1, 1, 0, E(0, 16'h0002, 0, 0, 0), "load_ignores_zero");
        cyc(0, 0, 4'd0, 0, 0, 1, 1, 0, E(1, 16'h0002, 0, 1, 0), "run_sees_zero");
        cyc(0, 0, 4'd0, 1, 0, 1, 1, 0, E(1, 16'h0002, 0, 0, 1), "done_start");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "done_start_exit");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    task automatic test_clear_run();
        logic [19:0] e, a; string n;
        cyc(0, 1, 4'd7, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "key7");
        cyc(0, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0007, 0, 0, 0), "start7");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(0, 16'h0007, 0, 0, 0), "load7");
        cyc(1, 0, 4'd0, 1, 0, 1, 0, 1, E(1, 16'h0007, 1, 1, 0), "clear_in_run");
        cyc(1, 0, 4'd0, 1, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "after_clear");
        cyc(0, 0, 4'd0, 0, 0, 1, 0, 0, E(1, 16'h0000, 0, 0, 0), "idle_after_clear");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL %s: got %h expected %h", n, a, e); end
        end
    endtask

    initial begin
        clear = 1'b1; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b0; timer_zero = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_keys();
        test_start_stop();
        test_run_done();
        test_pause();
        test_done_start();
        test_clear_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
